// File: rtl/shared_ram_arbiter.sv
// -----------------------------------------------------------------------------
// shared_ram_arbiter
//
// Single-ported RAM shared by N_PORTS requesters through a round-robin
// arbiter. Each cycle at most one port is granted and the RAM performs at
// most one access. A clear request sweeps the whole RAM to zero, one word
// per cycle, while all requesters are held off.
//
// Ports
//   clk       in   clock, all state updates on the rising edge
//   rst       in   asynchronous active-high reset
//   req       in   [N_PORTS]            per-port access request
//   wrEn      in   [N_PORTS]            per-port write(1) / read(0) select
//   addr      in   [N_PORTS*ADDR_WIDTH] per-port address, port i at i*ADDR_WIDTH
//   dataIn    in   [N_PORTS*WIDTH]      per-port write data, port i at i*WIDTH
//   clrStart  in   one-cycle request to zero the whole memory
//   grant     out  [N_PORTS]            one-hot-or-zero grant, combinational
//   rdValid   out  [N_PORTS]            read data valid, one cycle after grant
//   dataOut   out  [WIDTH]              shared read data, held between reads
//   clrBusy   out  high while a clear sweep is running
// -----------------------------------------------------------------------------
module shared_ram_arbiter #(
    parameter int WIDTH      = 12,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int N_PORTS    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_PORTS-1:0]            req,
    input  logic [N_PORTS-1:0]            wrEn,
    input  logic [N_PORTS*ADDR_WIDTH-1:0] addr,
    input  logic [N_PORTS*WIDTH-1:0]      dataIn,
    input  logic                          clrStart,
    output logic [N_PORTS-1:0]            grant,
    output logic [N_PORTS-1:0]            rdValid,
    output logic [WIDTH-1:0]              dataOut,
    output logic                          clrBusy
);

    localparam int PTR_W = $clog2(N_PORTS);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]        last_q, last_d;
    logic [N_PORTS-1:0]      rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0]        data_out_q, data_out_d;
    logic                    clr_busy_q, clr_busy_d;

    logic [WIDTH-1:0]        mem_q [DEPTH];

    logic                    gnt_any;
    logic [PTR_W-1:0]        gnt_idx;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [WIDTH-1:0]        sel_data;
    logic                    sel_wr;

    // Round-robin pick: scan from the port after the last granted one,
    // wrapping, and take the first asserted request. No grant in CLEAR, in
    // the cycle clrStart is accepted, or while reset is held.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        int cand;
        cand    = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (state_q == IDLE && !clrStart && !rst) begin
            for (int k = 1; k <= N_PORTS; k++) begin
                cand = (int'(last_q) + k) % N_PORTS;
                if (!gnt_any && req[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = PTR_W'(cand);
                end
            end
        end
    end

    assign grant    = gnt_any ? (N_PORTS'(1) << gnt_idx) : '0;
    assign sel_addr = addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_data = dataIn[gnt_idx*WIDTH +: WIDTH];
    assign sel_wr   = wrEn[gnt_idx];

    // Next-state logic for the controller and its registered outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        rd_valid_d = '0;
        data_out_d = data_out_q;
        clr_busy_d = clr_busy_q;
        unique case (state_q)
            IDLE: begin
                if (clrStart) begin
                    state_d    = CLEAR;
                    cnt_d      = '0;
                    clr_busy_d = 1'b1;
                end else if (gnt_any) begin
                    last_d = gnt_idx;
                    if (!sel_wr) begin
                        rd_valid_d = grant;
                        data_out_d = mem_q[sel_addr];
                    end
                end
            end
            CLEAR: begin
                // clrStart is deliberately not looked at here: a second
                // pulse must not restart the sweep.
                if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    clr_busy_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
        endcase
    end

    // Controller state. The pointer resets to the last port so that the
    // first search after reset starts at port 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_q     <= PTR_W'(N_PORTS - 1);
            rd_valid_q <= '0;
            data_out_q <= '0;
            clr_busy_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of order.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            rd_valid_q <= rd_valid_d;
            data_out_q <= data_out_d;
            clr_busy_q <= clr_busy_d;
        end
    end

    // NOTE: the memory array has no reset; contents survive rst, and an
    // aborted clear leaves only the words already swept at zero.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem_q[cnt_q] <= '0;
        end else if (gnt_any && sel_wr) begin
            mem_q[sel_addr] <= sel_data;
        end
    end

    assign rdValid = rd_valid_q;
    assign dataOut = data_out_q;
    assign clrBusy = clr_busy_q;

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shared_ram_arbiter
//
// Self-checking bench for shared_ram_arbiter (WIDTH=12, DEPTH=256,
// N_PORTS=4). A behavioural model (plain arrays and integers) predicts
// grant, rdValid, dataOut and clrBusy every cycle; directed sequences cover
// the ordering, clear and reset corner cases, then a randomized phase runs
// requesters that hold their request until granted.
// -----------------------------------------------------------------------------
module tb_shared_ram_arbiter;

    localparam int W  = 12;
    localparam int D  = 256;
    localparam int AW = 8;
    localparam int N  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    wrEn = '0;
    logic [N*AW-1:0] addr = '0;
    logic [N*W-1:0]  dataIn = '0;
    logic            clrStart = 1'b0;
    logic [N-1:0]    grant;
    logic [N-1:0]    rdValid;
    logic [W-1:0]    dataOut;
    logic            clrBusy;

    shared_ram_arbiter #(
        .WIDTH     (W),
        .DEPTH     (D),
        .ADDR_WIDTH(AW),
        .N_PORTS   (N)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .wrEn     (wrEn),
        .addr     (addr),
        .dataIn   (dataIn),
        .clrStart (clrStart),
        .grant    (grant),
        .rdValid  (rdValid),
        .dataOut  (dataOut),
        .clrBusy  (clrBusy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] m_mem   [D];
    bit           m_known [D];
    int           m_last;
    bit           m_clr;
    int           m_cnt;
    logic [N-1:0] m_rdv;
    logic [W-1:0] m_dout;
    bit           m_dout_known;

    function automatic void model_reset();
        m_last       = N - 1;
        m_clr        = 1'b0;
        m_cnt        = 0;
        m_rdv        = '0;
        m_dout       = '0;
        m_dout_known = 1'b1;
    endfunction

    // Port that should be granted this cycle, -1 for none.
    function automatic int model_pick();
        if (rst || m_clr || clrStart) return -1;
        for (int k = 1; k <= N; k++) begin
            if (req[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    function automatic void model_edge(input int p);
        int a;
        if (rst) return;
        m_rdv = '0;
        if (m_clr) begin
            m_mem[m_cnt]   = '0;
            m_known[m_cnt] = 1'b1;
            m_cnt++;
            if (m_cnt == D) begin
                m_clr = 1'b0;
                m_cnt = 0;
            end
        end else if (clrStart) begin
            m_clr = 1'b1;
            m_cnt = 0;
        end else if (p >= 0) begin
            a      = int'(addr[p*AW +: AW]);
            m_last = p;
            if (wrEn[p]) begin
                m_mem[a]   = dataIn[p*W +: W];
                m_known[a] = 1'b1;
            end else begin
                m_rdv[p]     = 1'b1;
                m_dout       = m_mem[a];
                m_dout_known = m_known[a];
            end
        end
    endfunction

    // ---------------- cycle driver ----------------
    logic [N-1:0] g_seen;
    logic [N-1:0] obs_rdv;
    logic [W-1:0] obs_dout;
    int           busy_cnt;
    int           clr_grants;

    // Called just after a rising edge; checks outputs at the falling edge,
    // then advances the model at the next rising edge.
    task automatic step();
        int           p;
        logic [N-1:0] eg;
        @(negedge clk);
        p  = model_pick();
        eg = (p >= 0) ? (N'(1) << p) : '0;
        g_seen   = grant;
        obs_rdv  = rdValid;
        obs_dout = dataOut;
        if (clrBusy) busy_cnt++;
        if (clrBusy && grant != '0) clr_grants++;
        check("grant", 32'(grant), 32'(eg));
        check("clrBusy", 32'(clrBusy), 32'(m_clr));
        check("rdValid", 32'(rdValid), 32'(m_rdv));
        if (m_dout_known) check("dataOut", 32'(dataOut), 32'(m_dout));
        @(posedge clk);
        model_edge(p);
        #1;
    endtask

    task automatic set_port(input int p, input bit r, input bit w, input int a, input int d);
        req[p]            = r;
        wrEn[p]           = w;
        addr[p*AW +: AW]  = AW'(a);
        dataIn[p*W +: W]  = W'(d);
    endtask

    task automatic idle_ports();
        for (int p = 0; p < N; p++) set_port(p, 1'b0, 1'b0, 0, 0);
    endtask

    // Start a clear, optionally re-pulse clrStart at a given clear cycle,
    // and confirm the sweep lasts exactly D cycles with no grants.
    task automatic run_clear(input int pulse_at);
        clrStart = 1'b1;
        busy_cnt = 0;
        clr_grants = 0;
        step();
        clrStart = 1'b0;
        check("clr_start_nogrant", 32'(g_seen), 32'h0);
        for (int i = 0; i < 400; i++) begin
            clrStart = (i == pulse_at);
            step();
            if (!clrBusy) break;
        end
        clrStart = 1'b0;
        check("clr_length", 32'(busy_cnt), 32'(D));
        check("clr_no_grant", 32'(clr_grants), 32'h0);
    endtask

    // ---------------- stimulus ----------------
    logic [N-1:0] exp_seq [5];

    initial begin
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
        exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;

        // Reset with every port requesting: grant must stay zero.
        for (int p = 0; p < N; p++) set_port(p, 1'b1, 1'b1, 8'h20 + p, 12'h100 + p);
        model_reset();
        repeat (3) step();
        check("rst_grant", 32'(g_seen), 32'h0);
        check("rst_rdvalid", 32'(obs_rdv), 32'h0);
        check("rst_dataout", 32'(obs_dout), 32'h0);
        rst = 1'b0;

        // All four request continuously from reset: 0,1,2,3,0.
        for (int i = 0; i < 5; i++) begin
            step();
            check("rr_order", 32'(g_seen), 32'(exp_seq[i]));
        end
        idle_ports();

        // Port 2 alone, then ports 2 and 3.
        set_port(2, 1'b1, 1'b1, 8'h30, 12'h222);
        step();
        check("p2_alone", 32'(g_seen), 32'h4);
        set_port(3, 1'b1, 1'b1, 8'h31, 12'h333);
        step();
        check("p23_first", 32'(g_seen), 32'h8);
        step();
        check("p23_second", 32'(g_seen), 32'h4);
        idle_ports();

        // Port 1 write then read of 0x10.
        set_port(1, 1'b1, 1'b1, 8'h10, 12'hABC);
        step();
        check("p1_wr_grant", 32'(g_seen), 32'h2);
        set_port(1, 1'b1, 1'b0, 8'h10, 0);
        step();
        check("p1_rd_grant", 32'(g_seen), 32'h2);
        idle_ports();
        step();
        check("p1_rd_valid", 32'(obs_rdv), 32'h2);
        check("p1_rd_data", 32'(obs_dout), 32'hABC);

        // Write 0x5A5 to 0xFF, read 0x10 on port 3 just before the clear,
        // keep port 0 reading 0xFF through the clear.
        set_port(0, 1'b1, 1'b1, 8'hFF, 12'h5A5);
        step();
        check("p0_wr_grant", 32'(g_seen), 32'h1);
        idle_ports();
        set_port(3, 1'b1, 1'b0, 8'h10, 0);
        step();
        check("pre_clr_rd_grant", 32'(g_seen), 32'h8);
        idle_ports();
        set_port(0, 1'b1, 1'b0, 8'hFF, 0);
        clrStart = 1'b1;
        busy_cnt = 0;
        clr_grants = 0;
        step();
        clrStart = 1'b0;
        check("pre_clr_rd_valid", 32'(obs_rdv), 32'h8);
        check("pre_clr_rd_data", 32'(obs_dout), 32'hABC);
        check("clr_start_nogrant", 32'(g_seen), 32'h0);
        for (int i = 0; i < 400; i++) begin
            step();
            if (!clrBusy) break;
        end
        check("clr_length", 32'(busy_cnt), 32'(D));
        check("clr_no_grant", 32'(clr_grants), 32'h0);
        step();
        check("post_clr_grant", 32'(g_seen), 32'h1);
        idle_ports();
        step();
        check("post_clr_rd_valid", 32'(obs_rdv), 32'h1);
        check("post_clr_rd_data", 32'(obs_dout), 32'h000);

        // Second clrStart pulse at clear cycle 50 is ignored.
        run_clear(50);

        // Reset at clear cycle 100 aborts the sweep.
        set_port(2, 1'b1, 1'b1, 8'h10, 12'h123);
        step();
        set_port(2, 1'b1, 1'b1, 8'hFF, 12'h777);
        step();
        idle_ports();
        clrStart = 1'b1;
        step();
        clrStart = 1'b0;
        repeat (100) step();
        rst = 1'b1;
        model_reset();
        #1;
        check("abort_busy", 32'(clrBusy), 32'h0);
        check("abort_grant", 32'(grant), 32'h0);
        check("abort_rdvalid", 32'(rdValid), 32'h0);
        check("abort_dataout", 32'(dataOut), 32'h0);
        repeat (2) step();
        rst = 1'b0;
        set_port(1, 1'b1, 1'b0, 8'h10, 0);
        step();
        set_port(1, 1'b1, 1'b0, 8'hFF, 0);
        step();
        check("abort_rd10_data", 32'(obs_dout), 32'h000);
        idle_ports();
        step();
        check("abort_rdFF_data", 32'(obs_dout), 32'h777);

        // Randomized requesters that hold their request until granted.
        for (int c = 0; c < 1500; c++) begin
            for (int p = 0; p < N; p++) begin
                if (g_seen[p] || !req[p]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        set_port(p, 1'b1, 1'($urandom_range(0, 1)),
                                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, D - 1))
                                                             : int'($urandom_range(0, 15)),
                                 int'($urandom));
                    end else begin
                        set_port(p, 1'b0, 1'b0, 0, 0);
                    end
                end
            end
            clrStart = ($urandom_range(0, 399) == 0);
            step();
        end
        clrStart = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
